alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl_pkg.sv | 26 ++
 rtl/alu_ctrl_watchdog.sv | 47 ++++
 rtl/alu_ctrl.sv | 153 +++++++++++++++
 tb/tb_alu_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared types and constants for the ALU controller
//
// Purpose : state enumeration, err_code encodings and data width used by
//           alu_ctrl and alu_ctrl_watchdog.
// Ports   : none (package)
package alu_ctrl_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_OVERFLOW = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_FETCH = 4'd1,
      S_ACK   = 4'd2,
      S_EXEC  = 4'd3,
      S_WAIT  = 4'd4,
      S_WRITE = 4'd5,
      S_WCHK  = 4'd6,
      S_DONE  = 4'd7,
      S_ERROR = 4'd8
   } state_t;

endpackage

// File: rtl/alu_ctrl_watchdog.sv
// rtl/alu_ctrl_watchdog.sv - cycle watchdog bounding the wait for alu_done
//
// Purpose : cleared by load_i, advances once per cycle while count_i is high,
//           and raises expire_o combinationally in the TIMEOUT_CYCLES-th
//           counted cycle so the controller leaves WAIT on that edge.
// Ports   : clk       - system clock
//           reset_n   - asynchronous active-low reset
//           load_i    - restart the count (issued in EXEC)
//           count_i   - count this cycle (high in WAIT)
//           expire_o  - timeout reached in the current counted cycle
module alu_ctrl_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset_n,
   input  logic load_i,
   input  logic count_i,
   output logic expire_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (count_i && !expire_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the number of WAIT cycles already elapsed, so the cycle in
   // which it equals TIMEOUT_CYCLES-1 is the last one allowed.
   assign expire_o = count_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - sequencer moving instructions from a FIFO through an ALU into a result FIFO
//
// Purpose : on start, repeatedly reads the instruction FIFO, issues each
//           instruction to the ALU, waits for completion and writes the
//           result to the result FIFO until the instruction FIFO reports
//           empty (done) or the result FIFO reports full (error).
// Config  : `define ALU_CTRL_TIMEOUT_EN to bound the wait for alu_done by
//           TIMEOUT_CYCLES (err_code 10); otherwise the wait is unbounded.
// Ports   : clk, reset_n                     - clock, async active-low reset
//           start                            - begin draining (ignored while busy)
//           rd_en_inst/inst_in/rd_ack_inst/rd_err_inst - instruction FIFO
//           alu_start/alu_inst/alu_done/alu_result     - ALU handshake
//           wr_en_result/result_out/wr_err_result      - result FIFO
//           busy, done, err_code, inst_count           - status
module alu_ctrl
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   output logic              rd_en_inst,
   input  logic [DATA_W-1:0] inst_in,
   input  logic              rd_ack_inst,
   input  logic              rd_err_inst,
   output logic              alu_start,
   output logic [DATA_W-1:0] alu_inst,
   input  logic              alu_done,
   input  logic [DATA_W-1:0] alu_result,
   output logic              wr_en_result,
   output logic [DATA_W-1:0] result_out,
   input  logic              wr_err_result,
   output logic              busy,
   output logic              done,
   output logic [1:0]        err_code,
   output logic [7:0]        inst_count
);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [1:0]        err_q, err_d;
   logic              wd_expire;

`ifdef ALU_CTRL_TIMEOUT_EN
   alu_ctrl_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .reset_n  (reset_n),
      .load_i   (state_q == S_EXEC),
      .count_i  (state_q == S_WAIT),
      .expire_o (wd_expire)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
   assign wd_expire          = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      inst_d  = inst_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d   = '0;
               err_d   = ERR_NONE;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_ACK;
         S_ACK: begin
            // FIFO answers one cycle after the read strobe; no answer means
            // the FIFO was not ready, so the read is simply retried.
            if (rd_ack_inst) begin
               inst_d  = inst_in;
               state_d = S_EXEC;
            end else if (rd_err_inst) begin
               state_d = S_DONE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_EXEC: state_d = S_WAIT;
         S_WAIT: begin
            if (alu_done) begin
               res_d   = alu_result;
               state_d = S_WRITE;
            end else if (wd_expire) begin
               err_d   = ERR_TIMEOUT;
               state_d = S_ERROR;
            end
         end
         S_WRITE: state_d = S_WCHK;
         S_WCHK: begin
            if (wr_err_result) begin
               err_d   = ERR_OVERFLOW;
               state_d = S_ERROR;
            end else begin
               if (cnt_q != 8'hFF) begin
                  cnt_d = cnt_q + 8'd1;
               end
               state_d = S_FETCH;
            end
         end
         S_DONE: state_d = S_IDLE;
         S_ERROR: begin
            if (start) begin
               cnt_d   = '0;
               err_d   = ERR_NONE;
               state_d = S_FETCH;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         inst_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         err_q   <= ERR_NONE;
      end else begin
         state_q <= state_d;
         inst_q  <= inst_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Strobes decode directly from distinct states, so they are mutually
   // exclusive and all low in IDLE (including the cycle after reset).
   assign rd_en_inst   = (state_q == S_FETCH);
   assign alu_start    = (state_q == S_EXEC);
   assign wr_en_result = (state_q == S_WRITE);
   assign done         = (state_q == S_DONE);
   assign busy         = !((state_q == S_IDLE) || (state_q == S_DONE) ||
                           (state_q == S_ERROR));
   assign alu_inst     = inst_q;
   assign result_out   = res_q;
   assign err_code     = err_q;
   assign inst_count   = cnt_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - self-checking bench for alu_ctrl with FIFO/ALU models and a result scoreboard
module tb_alu_ctrl;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        rd_en_inst;
   logic [31:0] inst_in;
   logic        rd_ack_inst;
   logic        rd_err_inst;
   logic        alu_start;
   logic [31:0] alu_inst;
   logic        alu_done;
   logic [31:0] alu_result;
   logic        wr_en_result;
   logic [31:0] result_out;
   logic        wr_err_result;
   logic        busy;
   logic        done;
   logic [1:0]  err_code;
   logic [7:0]  inst_count;

   int tests = 0;
   int fails = 0;

   logic [31:0] fifo[$];
   logic [31:0] exp_q[$];
   int          rd_cyc[$];

   int          cyc = 0;
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          alu_start_cnt = 0;
   int          alu_start_cyc = 0;
   int          err_to_cyc = 0;
   int          full_at = 0;
   int          alu_lat = 2;
   bit          alu_hold = 0;
   bit          spur_arm = 0;
   bit          rd_pend = 0;
   bit          wr_pend_err = 0;
   int          alu_cnt = 0;
   logic [31:0] alu_op = '0;

   alu_ctrl #(.TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .rd_en_inst   (rd_en_inst),
      .inst_in      (inst_in),
      .rd_ack_inst  (rd_ack_inst),
      .rd_err_inst  (rd_err_inst),
      .alu_start    (alu_start),
      .alu_inst     (alu_inst),
      .alu_done     (alu_done),
      .alu_result   (alu_result),
      .wr_en_result (wr_en_result),
      .result_out   (result_out),
      .wr_err_result(wr_err_result),
      .busy         (busy),
      .done         (done),
      .err_code     (err_code),
      .inst_count   (inst_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Environment: instruction FIFO, ALU and result FIFO models, scoreboard
   // pop/compare and strobe-exclusivity monitor. Inputs change on negedge.
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         rd_ack_inst   = 1'b0;
         rd_err_inst   = 1'b0;
         alu_done      = 1'b0;
         wr_err_result = 1'b0;
         if (!reset_n) begin
            rd_pend     = 0;
            wr_pend_err = 0;
            alu_cnt     = 0;
         end else begin
            if (rd_pend) begin
               if (fifo.size() > 0) begin
                  inst_in     = fifo.pop_front();
                  rd_ack_inst = 1'b1;
               end else begin
                  rd_err_inst = 1'b1;
               end
            end
            rd_pend = rd_en_inst;
            if (rd_en_inst) begin
               rd_cnt++;
               rd_cyc.push_back(cyc);
            end
            if (alu_cnt > 0) begin
               alu_cnt--;
               if (alu_cnt == 0) begin
                  alu_done   = 1'b1;
                  alu_result = alu_op + 32'h100;
               end
            end
            if (alu_start) begin
               alu_cnt = alu_hold ? 0 : alu_lat;
               alu_op  = alu_inst;
               alu_start_cnt++;
               alu_start_cyc = cyc;
            end
            if (spur_arm && rd_en_inst) begin
               alu_done   = 1'b1;
               alu_result = 32'hDEAD_BEEF;
               spur_arm   = 0;
            end
            if (wr_pend_err) wr_err_result = 1'b1;
            wr_pend_err = 0;
            if (wr_en_result) begin
               wr_cnt++;
               wr_pend_err = (wr_cnt == full_at);
               tests++;
               if (exp_q.size() == 0) begin
                  fails++;
                  $display("FAIL scoreboard_extra: got write 0x%08h, required no write", result_out);
               end else begin
                  logic [31:0] e;
                  e = exp_q.pop_front();
                  if (result_out !== e) begin
                     fails++;
                     $display("FAIL scoreboard_data: got 0x%08h, required 0x%08h", result_out, e);
                  end
               end
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (err_code == 2'b10 && err_to_cyc == 0) err_to_cyc = cyc;
         end
         tests++;
         if ((32'(rd_en_inst) + 32'(alu_start) + 32'(wr_en_result)) > 1) begin
            fails++;
            $display("FAIL strobe_exclusive: rd=%0b alu=%0b wr=%0b, required at most one", rd_en_inst, alu_start, wr_en_result);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1);
   end

   task automatic clear_counters();
      rd_cnt = 0; rd_cyc.delete(); wr_cnt = 0; done_cnt = 0; done_cyc = 0;
      alu_start_cnt = 0; alu_start_cyc = 0; err_to_cyc = 0; full_at = 0;
      exp_q.delete(); fifo.delete();
   endtask

   task automatic load_insts(input int n, input logic [31:0] base);
      for (int i = 0; i < n; i++) begin
         fifo.push_back(base + 32'(i));
         exp_q.push_back(base + 32'(i) + 32'h100);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (done_cnt == 0) begin
         fails++;
         $display("FAIL %s_done_timeout: no done within %0d cycles, required done", name, budget);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({busy, done, rd_en_inst, alu_start, wr_en_result} !== 5'b0 ||
          alu_inst !== 32'h0 || result_out !== 32'h0 || err_code !== 2'b00 || inst_count !== 8'h0) begin
         fails++;
         $display("FAIL reset_outputs: busy=%0b done=%0b rd=%0b alu=%0b wr=%0b inst=%h res=%h err=%b cnt=%0d, required all 0",
                  busy, done, rd_en_inst, alu_start, wr_en_result, alu_inst, result_out, err_code, inst_count);
      end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      clear_counters();
      alu_lat = 2;
      load_insts(3, 32'h1);
      pulse_start();
      wait_done(200, "basic");
      tests++;
      if (inst_count !== 8'd3) begin fails++; $display("FAIL basic_count: got %0d, required 3", inst_count); end
      tests++;
      if (err_code !== 2'b00) begin fails++; $display("FAIL basic_err: got %b, required 00", err_code); end
      tests++;
      if (wr_cnt != 3 || exp_q.size() != 0) begin fails++; $display("FAIL basic_writes: got %0d left %0d, required 3 left 0", wr_cnt, exp_q.size()); end
      tests++;
      if (done_cnt != 1 || busy !== 1'b0) begin fails++; $display("FAIL basic_done: got %0d busy %0b, required 1 busy 0", done_cnt, busy); end
      tests++;
      if (alu_inst !== 32'h3) begin fails++; $display("FAIL basic_alu_inst_hold: got 0x%08h, required 0x00000003", alu_inst); end
   endtask

   task automatic test_empty();
      clear_counters();
      pulse_start();
      wait_done(50, "empty");
      tests++;
      if (rd_cnt != 1) begin fails++; $display("FAIL empty_reads: got %0d, required 1", rd_cnt); end
      tests++;
      if (rd_cyc.size() < 1 || done_cyc - rd_cyc[0] != 2) begin fails++; $display("FAIL empty_done_latency: got %0d, required 2", done_cyc - (rd_cyc.size() > 0 ? rd_cyc[0] : 0)); end
      tests++;
      if (inst_count !== 8'd0 || err_code !== 2'b00) begin fails++; $display("FAIL empty_status: got cnt %0d err %b, required 0 00", inst_count, err_code); end
   endtask

   task automatic test_overflow();
      int n = 0;
      clear_counters();
      alu_lat = 1;
      load_insts(4, 32'h10);
      full_at = 2;
      pulse_start();
      while (err_code == 2'b00 && n < 200) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      tests++;
      if (err_code !== 2'b01) begin fails++; $display("FAIL ovf_err: got %b, required 01", err_code); end
      tests++;
      if (inst_count !== 8'd1 || busy !== 1'b0) begin fails++; $display("FAIL ovf_state: got cnt %0d busy %0b, required 1 0", inst_count, busy); end
      tests++;
      if (rd_cnt != 2) begin fails++; $display("FAIL ovf_halt: got %0d reads, required 2", rd_cnt); end
      pulse_start();
      tests++;
      if (err_code !== 2'b00 || inst_count !== 8'd0 || busy !== 1'b1) begin fails++; $display("FAIL ovf_restart: got err %b cnt %0d busy %0b, required 00 0 1", err_code, inst_count, busy); end
      wait_done(200, "ovf");
      tests++;
      if (inst_count !== 8'd2 || err_code !== 2'b00) begin fails++; $display("FAIL ovf_resume: got cnt %0d err %b, required 2 00", inst_count, err_code); end
      tests++;
      if (wr_cnt != 4 || exp_q.size() != 0) begin fails++; $display("FAIL ovf_writes: got %0d left %0d, required 4 left 0", wr_cnt, exp_q.size()); end
   endtask

   task automatic test_timeout();
      clear_counters();
      alu_hold = 1;
      fifo.push_back(32'h77);
      pulse_start();
`ifdef ALU_CTRL_TIMEOUT_EN
      begin
         int n = 0;
         while (err_code == 2'b00 && n < 200) begin @(negedge clk); n++; end
         @(negedge clk);
      end
      tests++;
      if (err_code !== 2'b10 || busy !== 1'b0) begin fails++; $display("FAIL tmo_err: got %b busy %0b, required 10 0", err_code, busy); end
      tests++;
      if (err_to_cyc - alu_start_cyc != 9) begin fails++; $display("FAIL tmo_cycles: got %0d, required 9", err_to_cyc - alu_start_cyc); end
`else
      repeat (100) @(negedge clk);
      tests++;
      if (busy !== 1'b1 || err_code !== 2'b00) begin fails++; $display("FAIL tmo_unbounded: got busy %0b err %b, required 1 00", busy, err_code); end
      tests++;
      if (alu_start_cnt != 1 || wr_cnt != 0) begin fails++; $display("FAIL tmo_stall: got starts %0d writes %0d, required 1 0", alu_start_cnt, wr_cnt); end
`endif
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      alu_hold = 0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int n = 0;
      clear_counters();
      alu_hold = 1;
      fifo.push_back(32'h5);
      pulse_start();
      while (alu_start_cnt == 0 && n < 50) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if ({busy, done, rd_en_inst, alu_start, wr_en_result} !== 5'b0 ||
          alu_inst !== 32'h0 || result_out !== 32'h0 || err_code !== 2'b00 || inst_count !== 8'h0) begin
         fails++;
         $display("FAIL midreset_outputs: busy=%0b rd=%0b alu=%0b wr=%0b inst=%h cnt=%0d, required all 0",
                  busy, rd_en_inst, alu_start, wr_en_result, alu_inst, inst_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if ({busy, rd_en_inst, alu_start, wr_en_result} !== 4'b0) begin fails++; $display("FAIL midreset_release: got busy %0b rd %0b alu %0b wr %0b, required 0", busy, rd_en_inst, alu_start, wr_en_result); end
      @(negedge clk);
      alu_hold = 0;
      alu_lat = 1;
      clear_counters();
      load_insts(1, 32'h55);
      pulse_start();
      wait_done(100, "midreset");
      tests++;
      if (inst_count !== 8'd1 || wr_cnt != 1 || exp_q.size() != 0) begin fails++; $display("FAIL midreset_resume: got cnt %0d writes %0d, required 1 1", inst_count, wr_cnt); end
   endtask

   task automatic test_ignore();
      int n = 0;
      clear_counters();
      alu_lat = 4;
      load_insts(2, 32'h21);
      spur_arm = 1;
      pulse_start();
      while (alu_start_cnt == 0 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      wait_done(200, "ignore");
      repeat (20) @(negedge clk);
      tests++;
      if (inst_count !== 8'd2 || err_code !== 2'b00) begin fails++; $display("FAIL ignore_status: got cnt %0d err %b, required 2 00", inst_count, err_code); end
      tests++;
      if (wr_cnt != 2 || exp_q.size() != 0 || rd_cnt != 3) begin fails++; $display("FAIL ignore_seq: got writes %0d reads %0d, required 2 3", wr_cnt, rd_cnt); end
      tests++;
      if (done_cnt != 1 || busy !== 1'b0) begin fails++; $display("FAIL ignore_done: got %0d busy %0b, required 1 0", done_cnt, busy); end
   endtask

   task automatic test_back_to_back();
      clear_counters();
      alu_lat = 1;
      load_insts(3, 32'hA);
      pulse_start();
      wait_done(200, "b2b");
      tests++;
      if (rd_cyc.size() < 3) begin
         fails++; $display("FAIL b2b_reads: got %0d, required at least 3", rd_cyc.size());
      end else if (rd_cyc[1] - rd_cyc[0] != 6 || rd_cyc[2] - rd_cyc[1] != 6) begin
         fails++; $display("FAIL b2b_latency: got %0d and %0d, required 6 and 6", rd_cyc[1] - rd_cyc[0], rd_cyc[2] - rd_cyc[1]);
      end
      tests++;
      if (inst_count !== 8'd3 || exp_q.size() != 0) begin fails++; $display("FAIL b2b_count: got %0d, required 3", inst_count); end
   endtask

   task automatic test_saturate();
      clear_counters();
      alu_lat = 1;
      load_insts(260, 32'h1000);
      pulse_start();
      wait_done(3000, "sat");
      tests++;
      if (inst_count !== 8'd255) begin fails++; $display("FAIL sat_count: got %0d, required 255", inst_count); end
      tests++;
      if (wr_cnt != 260 || exp_q.size() != 0) begin fails++; $display("FAIL sat_writes: got %0d, required 260", wr_cnt); end
   endtask

   initial begin
      reset_n       = 1'b0;
      start         = 1'b0;
      inst_in       = '0;
      rd_ack_inst   = 1'b0;
      rd_err_inst   = 1'b0;
      alu_done      = 1'b0;
      alu_result    = '0;
      wr_err_result = 1'b0;
      test_reset();
      test_basic();
      test_empty();
      test_overflow();
      test_timeout();
      test_reset_mid();
      test_ignore();
      test_back_to_back();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
